vc_read_scheduler: RTL and testbench
====================================

VC_READ_SCHEDULER -- requirements
Module: vc_read_scheduler

Interface
REQ-001 SHALL provide parameter NUM_VC, default 2, number of per-VC circular_buffer instances served (2..8).
REQ-002 SHALL provide parameter CREDIT_MAX, default VC_DEPTH (noc_params), downstream per-VC buffer depth.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port vc_empty_i  input  NUM_VC  is_empty of each VC buffer.
REQ-006 SHALL provide port vc_peek_i  input  NUM_VC x flit_t  peek_o (front flit) of each VC buffer.
REQ-007 SHALL provide port vc_read_o  output  NUM_VC  read_i strobe to each VC buffer, one-hot or zero.
REQ-008 SHALL provide port credit_i  input  NUM_VC  one-cycle credit return per downstream VC.
REQ-009 SHALL provide port flit_o  output  flit_t  forwarded flit, registered.
REQ-010 SHALL provide port flit_valid_o  output  1  flit_o valid this cycle.
REQ-011 SHALL provide port vc_id_o  output  $clog2(NUM_VC)  VC of flit_o.
REQ-012 SHALL provide port error_o  output  1  one-cycle pulse on dropped malformed flit.

Function
REQ-013 SHALL keep per-VC credit counter, width $clog2(CREDIT_MAX+1), reset to CREDIT_MAX.
REQ-014 SHALL decrement credit[v] on a forwarded read of v, increment on credit_i[v]; both same cycle -> unchanged; increment at CREDIT_MAX saturates, no wrap.
REQ-015 SHALL treat VC v as eligible when !vc_empty_i[v] and credit[v] != 0.
REQ-016 SHALL implement FSM IDLE / LOCKED, plus registers lock_vc and rr_ptr.
REQ-017 IDLE: SHALL grant the first eligible VC with front flit_label HEAD or HEADTAIL, searching rr_ptr, rr_ptr+1, ... modulo NUM_VC.
REQ-018 Grant SHALL assert vc_read_o[g] combinationally in the grant cycle; at the next edge flit_o <= vc_peek_i[g], vc_id_o <= g, flit_valid_o <= 1 (latency 1 cycle).
REQ-019 HEAD granted -> LOCKED with lock_vc = g; HEADTAIL granted -> stay IDLE, rr_ptr <= g+1 mod NUM_VC.
REQ-020 LOCKED: SHALL consider only lock_vc; read when eligible, otherwise stall with vc_read_o = 0 and state held.
REQ-021 LOCKED: reading TAIL SHALL return to IDLE, rr_ptr <= lock_vc+1 mod NUM_VC; BODY stays LOCKED.
REQ-022 IDLE with BODY/TAIL front at rr-selected VC (non-empty, credit irrelevant) SHALL read and drop it: no flit_valid_o, no credit change, error_o pulses next cycle; this check takes priority over HEAD grant that cycle.
REQ-023 LOCKED with HEAD/HEADTAIL front on lock_vc SHALL forward nothing, pulse error_o, and return to IDLE without reading.
REQ-024 SHALL issue at most one vc_read_o per cycle; never read an empty VC; never forward with credit 0.
REQ-025 flit_valid_o SHALL deassert the cycle after any non-forwarding cycle; flit_o holds last value.

Reset
REQ-026 rst high at an edge SHALL set state IDLE, rr_ptr 0, lock_vc 0, all credits CREDIT_MAX, flit_o '0, vc_id_o 0, flit_valid_o 0, error_o 0.
REQ-027 vc_read_o SHALL be 0 whenever rst is high, including reset asserted mid-packet; in-flight packet is abandoned, credits restored.

Verification
REQ-028 VC0 holds HEAD,BODY,TAIL, VC1 empty, credits 4 -> reads cycles 0,1,2; flit_valid_o cycles 1-3 vc_id_o 0; credit[0]=1; rr_ptr=1.
REQ-029 VC0 and VC1 each hold a HEADTAIL, rr_ptr 0 -> VC0 forwarded first, then VC1 next cycle; rr_ptr ends 0.
REQ-030 VC0 HEAD,BODY with credit[0]=2, no credit_i -> two flits forwarded, VC0 TAIL stalls LOCKED; VC1 HEAD not granted; credit_i[0] pulse -> TAIL forwarded next cycle.
REQ-031 credit_i[0] and forward on VC0 same cycle at credit 3 -> credit stays 3; credit_i at CREDIT_MAX -> stays CREDIT_MAX.
REQ-032 IDLE, VC0 front BODY -> VC0 read, flit_valid_o 0, error_o 1 one cycle later, credit[0] unchanged.
REQ-033 rst asserted while LOCKED after HEAD -> next cycle state IDLE, credits CREDIT_MAX, flit_valid_o 0, vc_read_o 0 during reset.

Source files
------------

// File: rtl/vc_read_scheduler.sv
// Wormhole read scheduler: pulls flits from per-VC buffers, holds a VC for a whole
// packet, tracks downstream credits and drops flits whose label breaks packet framing.
package noc_params;
    localparam int VC_DEPTH    = 4;
    localparam int FLIT_DATA_W = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;
endpackage

module vc_read_scheduler
    import noc_params::*;
#(
    parameter int NUM_VC     = 2,
    parameter int CREDIT_MAX = VC_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_VC-1:0]         vc_empty_i,
    input  flit_t [NUM_VC-1:0]        vc_peek_i,
    output logic [NUM_VC-1:0]         vc_read_o,
    input  logic [NUM_VC-1:0]         credit_i,
    output flit_t                     flit_o,
    output logic                      flit_valid_o,
    output logic [$clog2(NUM_VC)-1:0] vc_id_o,
    output logic                      error_o
);

    localparam int VC_W = $clog2(NUM_VC);
    localparam int CW   = $clog2(CREDIT_MAX + 1);
    localparam logic [VC_W:0]   NUM_VC_L    = (VC_W + 1)'(NUM_VC);
    localparam logic [CW-1:0]   CREDIT_FULL = CW'(CREDIT_MAX);
    localparam logic [VC_W-1:0] LAST_VC     = VC_W'(NUM_VC - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [VC_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [VC_W-1:0]   lock_vc_reg, lock_vc_next;
    logic [CW-1:0]     credit_reg  [NUM_VC];
    logic [CW-1:0]     credit_next [NUM_VC];

    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] is_head;
    logic [VC_W-1:0]   cand_idx [NUM_VC];
    logic [NUM_VC-1:0] cand_ok;
    logic              grant_found;
    logic [VC_W-1:0]   grant_vc;
    logic              do_read;
    logic              do_forward;
    logic              do_error;
    logic [VC_W-1:0]   sel_vc;
    logic [NUM_VC-1:0] sel_onehot;
    logic [NUM_VC-1:0] fwd_vec;

    function automatic logic [VC_W-1:0] wrap_inc(input logic [VC_W-1:0] v);
        wrap_inc = (v == LAST_VC) ? '0 : v + VC_W'(1);
    endfunction

    // Per-VC status, round-robin candidate order starting at rr_ptr, credit update.
    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic [VC_W:0] sum;
            logic [VC_W:0] wrapped;

            assign is_head[gi]  = (vc_peek_i[gi].flit_label == HEAD) ||
                                  (vc_peek_i[gi].flit_label == HEADTAIL);
            assign eligible[gi] = !vc_empty_i[gi] && (credit_reg[gi] != '0);

            assign sum          = {1'b0, rr_ptr_reg} + (VC_W + 1)'(gi);
            assign wrapped      = sum - NUM_VC_L;
            assign cand_idx[gi] = (sum >= NUM_VC_L) ? wrapped[VC_W-1:0] : sum[VC_W-1:0];
            assign cand_ok[gi]  = eligible[cand_idx[gi]] && is_head[cand_idx[gi]];

            assign sel_onehot[gi] = (sel_vc == VC_W'(gi));

            // Simultaneous forward and credit return cancel out.
            assign credit_next[gi] =
                (fwd_vec[gi] && !credit_i[gi]) ? credit_reg[gi] - CW'(1) :
                (!fwd_vec[gi] && credit_i[gi] && (credit_reg[gi] != CREDIT_FULL))
                                               ? credit_reg[gi] + CW'(1) :
                                                 credit_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            lock_vc_reg  <= '0;
            flit_o       <= '0;
            vc_id_o      <= '0;
            flit_valid_o <= 1'b0;
            error_o      <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_reg[v] <= CREDIT_FULL;
            end
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_vc_reg  <= lock_vc_next;
            flit_valid_o <= do_forward;
            error_o      <= do_error;
            if (do_forward) begin
                flit_o  <= vc_peek_i[sel_vc];
                vc_id_o <= sel_vc;
            end
            for (int v = 0; v < NUM_VC; v++) begin
                credit_reg[v] <= credit_next[v];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        lock_vc_next = lock_vc_reg;
        do_read      = 1'b0;
        do_forward   = 1'b0;
        do_error     = 1'b0;
        sel_vc       = rr_ptr_reg;
        grant_found  = 1'b0;
        grant_vc     = rr_ptr_reg;

        // Descending scan so the candidate closest to rr_ptr wins.
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (cand_ok[i]) begin
                grant_found = 1'b1;
                grant_vc    = cand_idx[i];
            end
        end

        case (state_reg)
            IDLE: begin
                if (!vc_empty_i[rr_ptr_reg] && !is_head[rr_ptr_reg]) begin
                    // Orphan BODY/TAIL: consume it without forwarding or spending credit.
                    do_read  = 1'b1;
                    do_error = 1'b1;
                    sel_vc   = rr_ptr_reg;
                end else if (grant_found) begin
                    do_read    = 1'b1;
                    do_forward = 1'b1;
                    sel_vc     = grant_vc;
                    if (vc_peek_i[grant_vc].flit_label == HEADTAIL) begin
                        rr_ptr_next = wrap_inc(grant_vc);
                    end else begin
                        state_next   = LOCKED;
                        lock_vc_next = grant_vc;
                    end
                end
            end
            LOCKED: begin
                sel_vc = lock_vc_reg;
                if (!vc_empty_i[lock_vc_reg] && is_head[lock_vc_reg]) begin
                    // New packet started before the old one closed; abandon it unread.
                    do_error   = 1'b1;
                    state_next = IDLE;
                end else if (eligible[lock_vc_reg]) begin
                    do_read    = 1'b1;
                    do_forward = 1'b1;
                    if (vc_peek_i[lock_vc_reg].flit_label == TAIL) begin
                        state_next  = IDLE;
                        rr_ptr_next = wrap_inc(lock_vc_reg);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        vc_read_o = '0;
        fwd_vec   = '0;
        if (!rst && do_read) begin
            vc_read_o = sel_onehot;
        end
        if (do_forward) begin
            fwd_vec = sel_onehot;
        end
    end

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Directed bench for vc_read_scheduler: queue-modelled VC buffers, expected flits
// pushed to a scoreboard when loaded, a negedge monitor pops and compares.
module tb_vc_read_scheduler;
    import noc_params::*;

    localparam int NV = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NV-1:0]   vc_empty_i;
    flit_t [NV-1:0]  vc_peek_i;
    logic [NV-1:0]   vc_read_o;
    logic [NV-1:0]   credit_i;
    flit_t           flit_o;
    logic            flit_valid_o;
    logic [0:0]      vc_id_o;
    logic            error_o;

    typedef struct packed {
        flit_t      flit;
        logic [0:0] vc;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    flit_t vcq0[$];
    flit_t vcq1[$];
    int    err_exp = 0;
    int    total = 0;
    int    bad = 0;
    logic [NV-1:0] rd_cap;

    vc_read_scheduler #(.NUM_VC(NV), .CREDIT_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .vc_empty_i   (vc_empty_i),
        .vc_peek_i    (vc_peek_i),
        .vc_read_o    (vc_read_o),
        .credit_i     (credit_i),
        .flit_o       (flit_o),
        .flit_valid_o (flit_valid_o),
        .vc_id_o      (vc_id_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    function automatic flit_t mk(input flit_label_t l, input logic [15:0] d);
        flit_t f;
        f.flit_label = l;
        f.data       = d;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic drive_fronts();
        vc_empty_i[0] = (vcq0.size() == 0);
        vc_empty_i[1] = (vcq1.size() == 0);
        vc_peek_i[0]  = (vcq0.size() != 0) ? vcq0[0] : '0;
        vc_peek_i[1]  = (vcq1.size() != 0) ? vcq1[0] : '0;
    endtask

    // Load a flit into a VC buffer; fwd=1 also books it on the scoreboard.
    task automatic load(input int v, input flit_t f, input bit fwd);
        exp_t e;
        if (v == 0) vcq0.push_back(f);
        else        vcq1.push_back(f);
        if (fwd) begin
            e.flit = f;
            e.vc   = 1'(v);
            exp_q.push_back(e);
        end
        drive_fronts();
    endtask

    // One cycle: check read strobe and valid mid-cycle, then pop buffers after the edge.
    task automatic tick(input logic [NV-1:0] exp_rd, input logic exp_v, input string name);
        @(negedge clk);
        chk({name, "_rd"}, 32'(vc_read_o), 32'(exp_rd));
        chk({name, "_v"}, 32'(flit_valid_o), 32'(exp_v));
        rd_cap = vc_read_o;
        @(posedge clk);
        #1;
        if (rd_cap[0] && vcq0.size() != 0) void'(vcq0.pop_front());
        if (rd_cap[1] && vcq1.size() != 0) void'(vcq1.pop_front());
        credit_i = '0;
        drive_fronts();
    endtask

    task automatic drain(input string name);
        tick(2'b00, 1'b0, {name, "_idle"});
        chk({name, "_flits_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_errs_left"}, 32'(err_exp), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        credit_i = '0;
        vcq0.delete();
        vcq1.delete();
        drive_fronts();
        tick(2'b00, 1'b0, "rst_a");
        tick(2'b00, 1'b0, "rst_b");
        chk("rst_flit_valid", 32'(flit_valid_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_vc_id", 32'(vc_id_o), 32'd0);
        chk("rst_flit", 32'(flit_o), 32'd0);
        chk("rst_credit0", 32'(dut.credit_reg[0]), 32'd4);
        chk("rst_credit1", 32'(dut.credit_reg[1]), 32'd4);
        chk("rst_rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
        chk("rst_lock_vc", 32'(dut.lock_vc_reg), 32'd0);
        chk("rst_state", 32'(dut.state_reg), 32'd0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (flit_valid_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_flit: got %0h vc %0d expected none", flit_o, vc_id_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (flit_o !== mon_e.flit || vc_id_o !== mon_e.vc) begin
                    bad++;
                    $display("FAIL flit_out: got %0h vc %0d expected %0h vc %0d",
                             flit_o, vc_id_o, mon_e.flit, mon_e.vc);
                end else begin
                    $display("ok   flit_out: %0h vc %0d", flit_o, vc_id_o);
                end
            end
        end
        if (error_o) begin
            total++;
            if (err_exp == 0) begin
                bad++;
                $display("FAIL unexpected_error: got error_o=1 expected 0");
            end else begin
                err_exp--;
                $display("ok   error_pulse");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        credit_i   = '0;
        vc_empty_i = '1;
        vc_peek_i  = '0;
        rd_cap     = '0;
        @(posedge clk);
        #1;
        do_reset();

        // HEAD, BODY, TAIL on VC0: three back-to-back reads, credit 4 -> 1, rr_ptr -> 1.
        load(0, mk(HEAD, 16'h0001), 1'b1);
        load(0, mk(BODY, 16'h0002), 1'b1);
        load(0, mk(TAIL, 16'h0003), 1'b1);
        tick(2'b01, 1'b0, "t1_c0");
        tick(2'b01, 1'b1, "t1_c1");
        tick(2'b01, 1'b1, "t1_c2");
        tick(2'b00, 1'b1, "t1_c3");
        chk("t1_credit0", 32'(dut.credit_reg[0]), 32'd1);
        chk("t1_rr_ptr", 32'(dut.rr_ptr_reg), 32'd1);
        chk("t1_state", 32'(dut.state_reg), 32'd0);
        drain("t1");

        // Two HEADTAILs: VC0 then VC1, rr_ptr wraps back to 0.
        do_reset();
        load(0, mk(HEADTAIL, 16'h0010), 1'b1);
        load(1, mk(HEADTAIL, 16'h0011), 1'b1);
        tick(2'b01, 1'b0, "t2_c0");
        tick(2'b10, 1'b1, "t2_c1");
        tick(2'b00, 1'b1, "t2_c2");
        chk("t2_rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
        drain("t2");

        // Credit exhaustion mid-packet: TAIL stalls LOCKED, VC1 HEAD waits, credit return resumes.
        do_reset();
        load(0, mk(HEADTAIL, 16'h0040), 1'b1);
        load(0, mk(HEADTAIL, 16'h0041), 1'b1);
        load(0, mk(HEAD, 16'h0020), 1'b1);
        load(0, mk(BODY, 16'h0021), 1'b1);
        load(0, mk(TAIL, 16'h0022), 1'b1);
        tick(2'b01, 1'b0, "t3_c0");
        tick(2'b01, 1'b1, "t3_c1");
        tick(2'b01, 1'b1, "t3_c2");
        load(1, mk(HEAD, 16'h0030), 1'b1);
        load(1, mk(TAIL, 16'h0031), 1'b1);
        tick(2'b01, 1'b1, "t3_c3");
        tick(2'b00, 1'b1, "t3_stall_a");
        tick(2'b00, 1'b0, "t3_stall_b");
        chk("t3_credit0_empty", 32'(dut.credit_reg[0]), 32'd0);
        chk("t3_locked", 32'(dut.state_reg), 32'd1);
        credit_i = 2'b01;
        tick(2'b00, 1'b0, "t3_credit_ret");
        tick(2'b01, 1'b0, "t3_tail");
        tick(2'b10, 1'b1, "t3_vc1_head");
        tick(2'b10, 1'b1, "t3_vc1_tail");
        tick(2'b00, 1'b1, "t3_end");
        drain("t3");

        // Credit return coinciding with a forward, then saturation at the maximum.
        do_reset();
        load(0, mk(HEADTAIL, 16'h0090), 1'b1);
        load(0, mk(HEADTAIL, 16'h0091), 1'b1);
        tick(2'b01, 1'b0, "t4_c0");
        credit_i = 2'b01;
        tick(2'b01, 1'b1, "t4_c1");
        chk("t4_credit_same_cycle", 32'(dut.credit_reg[0]), 32'd3);
        credit_i = 2'b01;
        tick(2'b00, 1'b1, "t4_c2");
        chk("t4_credit_back", 32'(dut.credit_reg[0]), 32'd4);
        credit_i = 2'b11;
        tick(2'b00, 1'b0, "t4_c3");
        chk("t4_credit0_sat", 32'(dut.credit_reg[0]), 32'd4);
        chk("t4_credit1_sat", 32'(dut.credit_reg[1]), 32'd4);
        drain("t4");

        // Orphan BODY dropped with an error pulse; orphan TAIL beats a VC1 HEAD in the same cycle.
        do_reset();
        load(0, mk(BODY, 16'h0050), 1'b0);
        err_exp++;
        tick(2'b01, 1'b0, "t5_drop_body");
        tick(2'b00, 1'b0, "t5_c1");
        chk("t5_credit0_kept", 32'(dut.credit_reg[0]), 32'd4);
        load(0, mk(TAIL, 16'h0051), 1'b0);
        load(1, mk(HEAD, 16'h0060), 1'b1);
        load(1, mk(TAIL, 16'h0061), 1'b1);
        err_exp++;
        tick(2'b01, 1'b0, "t5_drop_tail");
        tick(2'b10, 1'b0, "t5_vc1_head");
        tick(2'b10, 1'b1, "t5_vc1_tail");
        tick(2'b00, 1'b1, "t5_end");
        drain("t5");

        // HEAD arriving on a locked VC: nothing read, error, back to IDLE, then regranted.
        do_reset();
        load(0, mk(HEAD, 16'h0070), 1'b1);
        load(0, mk(HEAD, 16'h0071), 1'b1);
        load(0, mk(TAIL, 16'h0072), 1'b1);
        err_exp++;
        tick(2'b01, 1'b0, "t6_head");
        tick(2'b00, 1'b1, "t6_bad_head");
        tick(2'b01, 1'b0, "t6_regrant");
        tick(2'b01, 1'b1, "t6_tail");
        tick(2'b00, 1'b1, "t6_end");
        drain("t6");

        // Reset while LOCKED: read strobe gated during reset, state and credits restored.
        do_reset();
        load(0, mk(HEAD, 16'h0080), 1'b1);
        load(0, mk(BODY, 16'h0081), 1'b0);
        load(0, mk(TAIL, 16'h0082), 1'b0);
        tick(2'b01, 1'b0, "t7_head");
        rst = 1'b1;
        tick(2'b00, 1'b1, "t7_rst_gate");
        chk("t7_state_idle", 32'(dut.state_reg), 32'd0);
        chk("t7_credit0", 32'(dut.credit_reg[0]), 32'd4);
        chk("t7_flit_valid", 32'(flit_valid_o), 32'd0);
        do_reset();
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
